uart_rx_ovs: RTL and testbench

- Parametrised, oversampling UART receiver; next generation of the fixed 8-bit receiver.
- Configurable data width, parity mode and stop-bit count; mid-bit majority sampling; false-start rejection; parity, framing and overrun flags.
- Sits between the async serial pin and a byte/word consumer, with a valid/ready output handshake.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_rx_ovs.sv | 122 ++++++++++++
 tb/tb_uart_rx_ovs.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver and its matching transmitter.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Oversample index at which a bit is taken: the centre of the bit cell.
  function automatic int mid_sample(input int ovs);
    return ovs / 2;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Clock divider: one-clk tick every DIV enabled cycles, synchronous clear.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: majority-voted mid-bit sampling, parity/framing/overrun
// flags and a valid/ready output stage.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int DIV       = 27,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int SW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID     = SW'(mid_sample(OVS));
  localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_e state, state_nxt;
  logic [1:0]           sync;
  logic [1:0]           hist;   // two previous tick samples; rx_s is the third
  logic                 rx_s, tick, mid, maj, par_bad, armed, done;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        b_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_q, fe_q;

  assign rx_s    = sync[1];
  assign maj     = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
  assign mid     = tick && (s_cnt == S_MID);
  assign par_bad = (PARITY == PARITY_ODD) ? ~(^shreg ^ maj) : (^shreg ^ maj);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (en && (state != RX_IDLE)),
    .clr  (state == RX_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx_in};

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (!en) state_nxt = RX_IDLE;
    else begin
      case (state)
        RX_IDLE:   if (!rx_s && armed) state_nxt = RX_START;
        RX_START:  if (mid) state_nxt = maj ? RX_IDLE : RX_DATA;
        RX_DATA:   if (mid && b_cnt == B_LAST)
                     state_nxt = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
        RX_PARITY: if (mid) state_nxt = RX_STOP;
        RX_STOP:   if (mid && b_cnt == STOP_LAST) begin
                     state_nxt = RX_IDLE;
                     done      = 1'b1;
                   end
        default:   state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RX_IDLE;
      hist  <= 2'b11;
      armed <= 1'b0;
      s_cnt <= '0;
      b_cnt <= '0;
      shreg <= '0;
      pe_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tick) hist <= {hist[0], rx_s};
      if (state == RX_IDLE) s_cnt <= '0;
      else if (tick)        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
      if (state_nxt != state) b_cnt <= '0;
      else if (mid)           b_cnt <= b_cnt + 1'b1;
      // A start is only taken after the line has been seen high while idle,
      // so a held-low line (break, low final stop) yields a single word.
      if (state == RX_IDLE && state_nxt == RX_START) armed <= 1'b0;
      else if (state == RX_IDLE && rx_s)             armed <= 1'b1;
      if (state == RX_DATA && mid) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == RX_START)                  pe_q <= 1'b0;
      else if (state == RX_PARITY && mid)     pe_q <= par_bad;
      if (state == RX_START)                  fe_q <= 1'b0;
      else if (state == RX_STOP && mid && !maj) fe_q <= 1'b1;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && data_valid && !data_ready;
      if (done) begin
        data_out   <= shreg;
        parity_err <= pe_q;
        frame_err  <= fe_q | ~maj;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: an 8N1 instance and an 8E2 instance driven with serial frames.
module tb_uart_rx_ovs;
  localparam int DIV = 4;
  localparam int OVS = 16;
  localparam int BP  = DIV * OVS;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic dv_a, pe_a, fe_a, ov_a, dv_b, pe_b, fe_b, ov_b;
  int   n_cmp = 0, n_bad = 0;
  int   rise_a = 0, ovc_a = 0, ovc_b = 0;
  logic dvq_a = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ovs #(.DIV(DIV), .OVS(OVS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_in(rx_a), .data_out(dout_a), .data_valid(dv_a),
    .data_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a));

  uart_rx_ovs #(.DIV(DIV), .OVS(OVS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .rx_in(rx_b), .data_out(dout_b), .data_valid(dv_b),
    .data_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b));

  // delivery and overrun-cycle counters
  always @(posedge clk) begin
    if (dv_a && !dvq_a) rise_a <= rise_a + 1;
    dvq_a <= dv_a;
    if (ov_a) ovc_a <= ovc_a + 1;
    if (ov_b) ovc_b <= ovc_b + 1;
  end

  typedef struct {
    bit         sel_b;
    logic [7:0] d;
    logic       p;
    logic [1:0] st;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line bits LSB first: start, data, [parity], stop(s); each held one bit period.
  task automatic send(input bit sel_b, input logic [7:0] d, input logic p, input logic [1:0] st);
    logic [11:0] bits;
    int n;
    if (sel_b) begin bits = {st[1], st[0], p, d, 1'b0}; n = 12; end
    else       begin bits = {2'b11, st[0], d, 1'b0};    n = 10; end
    for (int i = 0; i < n; i++) begin
      if (sel_b) rx_b = bits[i]; else rx_a = bits[i];
      repeat (BP) @(negedge clk);
    end
    if (sel_b) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic expect_word(input bit sel_b, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
    check({tag, ".valid"}, sel_b ? dv_b : dv_a, 1);
    check({tag, ".data"},  sel_b ? dout_b : dout_a, d);
    check({tag, ".perr"},  sel_b ? pe_b : pe_a, pe);
    check({tag, ".ferr"},  sel_b ? fe_b : fe_a, fe);
  endtask

  task automatic accept(input bit sel_b, input string tag);
    if (sel_b) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    if (sel_b) rdy_b = 1'b0; else rdy_a = 1'b0;
    check({tag, ".drop"}, sel_b ? dv_b : dv_a, 0);
  endtask

  // Returns {frame_err, parity_err, data} from the frame contents alone.
  function automatic logic [9:0] model(input bit sel_b, input logic [7:0] d, input logic p,
                                       input logic [1:0] st);
    logic pe, fe;
    pe = sel_b ? ((^d) ^ p) : 1'b0;          // even parity: ones in data+p must be even
    fe = sel_b ? !(st[0] && st[1]) : !st[0];
    return {fe, pe, d};
  endfunction

  initial begin
    int lat, r0, o0;
    bit sb;
    logic [7:0] d;
    logic p;
    logic [1:0] st;
    logic [9:0] m;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 1'b1, 2'b10, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst.dv_a", dv_a, 0);
    check("rst.data_a", dout_a, 0);
    check("rst.flags_a", {pe_a, fe_a, ov_a}, 0);
    check("rst.dv_b", dv_b, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (BP) @(negedge clk);

    // first frame: latency from start edge to data_valid
    lat = 0;
    fork
      send(1'b0, 8'hA5, 1'b0, 2'b11);
      while (!dv_a && lat < 2000) begin @(negedge clk); lat++; end
    join
    n_cmp++;
    if (lat < 9*BP + BP/2 || lat > 9*BP + BP/2 + DIV + 8) begin
      n_bad++;
      $display("FAIL lat: got %0d clks, expected %0d..%0d", lat, 9*BP + BP/2, 9*BP + BP/2 + DIV + 8);
    end
    expect_word(1'b0, "first", 8'hA5, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("first.held", {dv_a, dout_a}, {1'b1, 8'hA5});
    accept(1'b0, "first");

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel_b, vecs[i].d, vecs[i].p, vecs[i].st);
      repeat (4) @(negedge clk);
      expect_word(vecs[i].sel_b, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      accept(vecs[i].sel_b, $sformatf("vec%0d", i));
      repeat (BP) @(negedge clk);
    end

    // short low glitch: false start, nothing delivered
    r0 = rise_a;
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (3*BP) @(negedge clk);
    check("glitch.dv", dv_a, 0);
    check("glitch.words", rise_a - r0, 0);

    // break: exactly one zero word with frame error until the line returns high
    r0 = rise_a;
    rx_a = 1'b0;
    repeat (14*BP) @(negedge clk);
    expect_word(1'b0, "brk", 8'h00, 1'b0, 1'b1);
    check("brk.words", rise_a - r0, 1);
    rx_a = 1'b1;
    repeat (2*BP) @(negedge clk);
    check("brk.words_after", rise_a - r0, 1);
    accept(1'b0, "brk");
    repeat (BP) @(negedge clk);

    // overrun: two back-to-back words with data_ready low
    o0 = ovc_a;
    send(1'b0, 8'h11, 1'b0, 2'b11);
    check("ovr.none_yet", ovc_a - o0, 0);
    send(1'b0, 8'h22, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    expect_word(1'b0, "ovr", 8'h22, 1'b0, 1'b0);
    check("ovr.pulse_clks", ovc_a - o0, 1);

    // async reset in data bit 3 while a word is still held
    fork
      send(1'b0, 8'hFF, 1'b0, 2'b11);
      begin
        repeat (4*BP + BP/2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst.dv", dv_a, 0);
        check("arst.data", dout_a, 0);
        check("arst.flags", {pe_a, fe_a, ov_a}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (BP) @(negedge clk);
    check("arst.no_word", dv_a, 0);
    send(1'b0, 8'h3C, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    expect_word(1'b0, "arst.rx", 8'h3C, 1'b0, 1'b0);

    // en dropped mid-frame: held word untouched, partial frame discarded
    r0 = rise_a;
    o0 = ovc_a;
    fork
      send(1'b0, 8'hFF, 1'b0, 2'b11);
      begin
        repeat (4*BP + BP/2) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
      end
    join
    repeat (BP) @(negedge clk);
    expect_word(1'b0, "en.held", 8'h3C, 1'b0, 1'b0);
    check("en.words", rise_a - r0, 0);
    check("en.ovr", ovc_a - o0, 0);
    accept(1'b0, "en");
    send(1'b0, 8'h3C, 1'b0, 2'b11);
    repeat (4) @(negedge clk);
    expect_word(1'b0, "en.rx", 8'h3C, 1'b0, 1'b0);
    accept(1'b0, "en.rx");
    repeat (BP) @(negedge clk);

    // randomized frames on both formats against the frame-level model
    for (int k = 0; k < 24; k++) begin
      sb = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      p  = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      m  = model(sb, d, p, st);
      send(sb, d, p, st);
      repeat (4) @(negedge clk);
      expect_word(sb, $sformatf("rnd%0d", k), m[7:0], m[8], m[9]);
      accept(sb, $sformatf("rnd%0d", k));
      repeat (BP/2) @(negedge clk);
    end
    check("b.no_overrun", ovc_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
